multi_slot_code_verifier: RTL and testbench
===========================================

// Module: multi_slot_code_verifier
// PURPOSE
// - Sequential successor to the single-pair master compare. Checks an entered code against NUM_SLOTS stored codes.
// - Slot 0 is the master code; slots 1..N-1 are user codes. Scans one slot per clock, so result latency is fixed.
// - Counts consecutive failures and enforces a timed lockout.
// - Sits between the keypad code assembler and the door actuator / alarm control.
// PARAMETERS
// - CODE_W       128   bits per code
// - NUM_SLOTS    4     stored code slots, >=1; slot 0 = master
// - MAX_FAIL     3     consecutive failures that trigger lockout, >=1
// - LOCK_CYCLES  1000  lockout duration in clk cycles, >=1
// - Derived: IDX_W = max(1,$clog2(NUM_SLOTS)), FC_W = $clog2(MAX_FAIL+1)
// PORTS
// - clk           in   1                 system clock, rising edge
// - rst_n         in   1                 asynchronous active-low reset
// - code_in       in   CODE_W            entered code; sampled on accepted confirm
// - confirm       in   1                 request pulse; accepted only in IDLE (see LOCKED)
// - slot_codes    in   NUM_SLOTS*CODE_W  slot k = [k*CODE_W +: CODE_W]; hold stable while busy
// - slot_valid    in   NUM_SLOTS         1 = slot programmed; invalid slots never match
// - busy          out  1                 1 in SCAN or RESULT
// - match         out  1                 1-cycle pulse: accepted code matched a valid slot
// - fail          out  1                 1-cycle pulse: no valid slot matched
// - match_slot    out  IDX_W             lowest matching slot index; valid with match, held until next result
// - match_master  out  1                 match_slot==0 qualifier; valid with match
// - locked        out  1                 1 while in LOCKED
// - fail_count    out  FC_W              consecutive failures since last match or lockout expiry
// BEHAVIOUR
// - Reset (async, rst_n=0): state IDLE; busy, match, fail, match_master, locked = 0; match_slot = 0; fail_count = 0.
//   All internal registers are cleared. An in-flight scan is discarded with no pulse.
// - IDLE: confirm=1 latches code_in, clears the hit flag, sets idx=0, goes to SCAN. busy rises next cycle.
// - SCAN: each cycle compares the latched code with slot idx.
//   - On the first hit (slot_valid[idx] && equal), record idx. Later hits are ignored, so the lowest index wins.
//   - Scanning always covers all NUM_SLOTS; there is no early exit.
//   - After idx==NUM_SLOTS-1, go to RESULT.
// - RESULT (one cycle): assert exactly one of match or fail.
//   - Latency: confirm sampled at edge T -> pulse high during cycle T+NUM_SLOTS+1.
//   - match: fail_count <= 0 and match_master <= (slot==0). Go to IDLE.
//   - fail: fail_count <= fail_count+1.
//     - If the new value equals MAX_FAIL: lock timer <= LOCK_CYCLES-1, go to LOCKED.
//     - Otherwise go to IDLE.
// - LOCKED: locked=1; the timer decrements each cycle.
//   - When the timer reaches 0: fail_count <= 0, locked <= 0, go to IDLE.
//   - confirm handling depends on CONFIGURATION.
// - confirm while busy is ignored; it is not queued.
// - All slot_valid=0 -> every attempt fails.
// - Duplicate codes across slots -> the lowest index is reported.
// - fail_count saturates at MAX_FAIL and never wraps.
// CONFIGURATION
// - Macro MASTER_OVERRIDE_EN.
// - Defined: confirm in LOCKED is compared in the same cycle against slot 0 only (slot_valid[0] must be 1).
//   - On a hit: the next cycle gives match=1, match_master=1, match_slot=0, fail_count=0, timer cleared, locked=0, state IDLE.
//   - On a miss: no fail pulse, fail_count unchanged, and the timer keeps running.
// - Undefined: confirm in LOCKED is ignored and the lockout always runs to completion.
// TESTING (NUM_SLOTS=4, MAX_FAIL=3, LOCK_CYCLES=20, CODE_W=128)
// - Reset, then confirm with code == slot2, all valid
//   -> match pulse exactly 5 cycles after confirm; match_slot=2; match_master=0; fail_count=0.
// - slot1 == slot3 == code, slot1 invalid -> match_slot=3. Then set slot0 == code, valid -> match_slot=0, match_master=1.
// - 3 wrong codes back-to-back -> fail pulses with fail_count 1, 2, 3.
//   - locked=1 for exactly 20 cycles, then locked=0 and fail_count=0.
//   - A 4th confirm during lockout -> no pulse.
// - 2 fails, then a correct code -> fail_count returns to 0. Then 2 more fails -> still unlocked, fail_count=2.
// - rst_n low mid-SCAN (idx=2) -> all outputs 0 immediately; no pulse after release; the next confirm behaves normally.
// - MASTER_OVERRIDE_EN: lock, then confirm with a user code at cycle 5 of lockout -> ignored.
//   Then confirm with the slot0 code -> match, match_master=1, locked=0 next cycle.

Source files
------------

// File: rtl/multi_slot_code_verifier.sv
// multi_slot_code_verifier
// Compares an entered code against NUM_SLOTS stored codes, one slot per clock,
// so the result always arrives a fixed number of cycles after confirm.
// Slot 0 is the master code. Consecutive failures are counted, and reaching
// MAX_FAIL starts a timed lockout.
// Optional feature macro: MASTER_OVERRIDE_EN. When it is defined, a confirm
// carrying the master code (slot 0) ends a lockout early. When it is undefined,
// confirm is ignored during lockout.
module multi_slot_code_verifier #(
    parameter int CODE_W      = 128,
    parameter int NUM_SLOTS   = 4,
    parameter int MAX_FAIL    = 3,
    parameter int LOCK_CYCLES = 1000,
    localparam int IDX_W      = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1,
    localparam int FC_W       = $clog2(MAX_FAIL + 1)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [CODE_W-1:0]             code_in,
    input  logic                          confirm,
    input  logic [NUM_SLOTS*CODE_W-1:0]   slot_codes,
    input  logic [NUM_SLOTS-1:0]          slot_valid,
    output logic                          busy,
    output logic                          match,
    output logic                          fail,
    output logic [IDX_W-1:0]              match_slot,
    output logic                          match_master,
    output logic                          locked,
    output logic [FC_W-1:0]               fail_count
);

    localparam int TMR_W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SLOTS - 1);
    localparam logic [FC_W-1:0]  FC_MAX   = FC_W'(MAX_FAIL);
    localparam logic [TMR_W-1:0] TMR_INIT = TMR_W'(LOCK_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SCAN   = 2'd1,
        ST_RESULT = 2'd2,
        ST_LOCKED = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [CODE_W-1:0]  code_q, code_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               hit_q, hit_d;
    logic [IDX_W-1:0]   hit_idx_q, hit_idx_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic               busy_q, busy_d;
    logic               match_q, match_d;
    logic               fail_q, fail_d;
    logic [IDX_W-1:0]   match_slot_q, match_slot_d;
    logic               match_master_q, match_master_d;
    logic               locked_q, locked_d;
    logic [FC_W-1:0]    fail_count_q, fail_count_d;

    // Per-slot view of the packed slot bus
    logic [CODE_W-1:0]  slot_word [NUM_SLOTS];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_SLOTS; gi++) begin : g_slot
            assign slot_word[gi] = slot_codes[gi*CODE_W +: CODE_W];
        end
    endgenerate

    // A single comparator is shared by all slots. It sees the slot selected by the scan index.
    logic cur_hit;
    assign cur_hit = slot_valid[idx_q] && (slot_word[idx_q] == code_q);

    // The fail counter saturates, so it can never wrap even if the lock path changes later.
    logic [FC_W-1:0] fc_inc;
    assign fc_inc = (fail_count_q < FC_MAX) ? (fail_count_q + FC_W'(1)) : FC_MAX;

`ifdef MASTER_OVERRIDE_EN
    // During lockout, the live keypad code is compared directly against the master slot.
    logic master_hit;
    assign master_hit = slot_valid[0] && (slot_word[0] == code_in);
`endif

    // Next-state and next-output logic for the scan/result/lockout sequence
    always_comb begin
        state_d        = state_q;
        code_d         = code_q;
        idx_d          = idx_q;
        hit_d          = hit_q;
        hit_idx_d      = hit_idx_q;
        timer_d        = timer_q;
        match_d        = 1'b0;
        fail_d         = 1'b0;
        match_slot_d   = match_slot_q;
        match_master_d = match_master_q;
        fail_count_d   = fail_count_q;

        case (state_q)
            ST_IDLE: begin
                if (confirm) begin
                    code_d    = code_in;
                    hit_d     = 1'b0;
                    hit_idx_d = '0;
                    idx_d     = '0;
                    state_d   = ST_SCAN;
                end
            end

            ST_SCAN: begin
                // Only the first hit is recorded, so the lowest index wins.
                if (cur_hit && !hit_q) begin
                    hit_d     = 1'b1;
                    hit_idx_d = idx_q;
                end
                // Every slot is visited, so latency does not depend on which slot matches.
                if (idx_q == LAST_IDX) begin
                    state_d = ST_RESULT;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end

            ST_RESULT: begin
                if (hit_q) begin
                    match_d        = 1'b1;
                    match_slot_d   = hit_idx_q;
                    match_master_d = (hit_idx_q == '0);
                    fail_count_d   = '0;
                    state_d        = ST_IDLE;
                end else begin
                    fail_d       = 1'b1;
                    fail_count_d = fc_inc;
                    if (fc_inc == FC_MAX) begin
                        timer_d = TMR_INIT;
                        state_d = ST_LOCKED;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end

            ST_LOCKED: begin
`ifdef MASTER_OVERRIDE_EN
                if (confirm && master_hit) begin
                    match_d        = 1'b1;
                    match_slot_d   = '0;
                    match_master_d = 1'b1;
                    fail_count_d   = '0;
                    timer_d        = '0;
                    state_d        = ST_IDLE;
                end else
`endif
                if (timer_q == '0) begin
                    fail_count_d = '0;
                    state_d      = ST_IDLE;
                end else begin
                    timer_d = timer_q - TMR_W'(1);
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // The status flags come from the next state, so they line up with it on the same edge.
        busy_d   = (state_d == ST_SCAN) || (state_d == ST_RESULT);
        locked_d = (state_d == ST_LOCKED);
    end

    // State and registered outputs. Reset discards any scan that is in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            code_q         <= '0;
            idx_q          <= '0;
            hit_q          <= 1'b0;
            hit_idx_q      <= '0;
            timer_q        <= '0;
            busy_q         <= 1'b0;
            match_q        <= 1'b0;
            fail_q         <= 1'b0;
            match_slot_q   <= '0;
            match_master_q <= 1'b0;
            locked_q       <= 1'b0;
            fail_count_q   <= '0;
        end else begin
            state_q        <= state_d;
            code_q         <= code_d;
            idx_q          <= idx_d;
            hit_q          <= hit_d;
            hit_idx_q      <= hit_idx_d;
            timer_q        <= timer_d;
            busy_q         <= busy_d;
            match_q        <= match_d;
            fail_q         <= fail_d;
            match_slot_q   <= match_slot_d;
            match_master_q <= match_master_d;
            locked_q       <= locked_d;
            fail_count_q   <= fail_count_d;
        end
    end

    assign busy         = busy_q;
    assign match        = match_q;
    assign fail         = fail_q;
    assign match_slot   = match_slot_q;
    assign match_master = match_master_q;
    assign locked       = locked_q;
    assign fail_count   = fail_count_q;

endmodule

// File: tb/tb_multi_slot_code_verifier.sv
// Directed testbench for multi_slot_code_verifier
// (NUM_SLOTS=4, MAX_FAIL=3, LOCK_CYCLES=20, CODE_W=128).
module tb_multi_slot_code_verifier;

    localparam int CODE_W = 128;
    localparam int NS     = 4;

    localparam logic [CODE_W-1:0] C0 = 128'h0000_1111_2222_3333_4444_5555_6666_7777;
    localparam logic [CODE_W-1:0] C1 = 128'h1234_5678_9abc_def0_0fed_cba9_8765_4321;
    localparam logic [CODE_W-1:0] C2 = 128'hdead_beef_cafe_f00d_0123_4567_89ab_cdef;
    localparam logic [CODE_W-1:0] C3 = 128'h5a5a_a5a5_5a5a_a5a5_0f0f_f0f0_3c3c_c3c3;
    localparam logic [CODE_W-1:0] CX = 128'h7777_8888_9999_aaaa_bbbb_cccc_dddd_eeee;
    localparam logic [CODE_W-1:0] CW = 128'hffff_0000_ffff_0000_1357_9bdf_2468_ace0;

    logic                   clk;
    logic                   rst_n;
    logic [CODE_W-1:0]      code_in;
    logic                   confirm;
    logic [NS*CODE_W-1:0]   slot_codes;
    logic [NS-1:0]          slot_valid;
    logic                   busy;
    logic                   match;
    logic                   fail;
    logic [1:0]             match_slot;
    logic                   match_master;
    logic                   locked;
    logic [1:0]             fail_count;

    int checks   = 0;
    int failures = 0;

    multi_slot_code_verifier #(
        .CODE_W      (CODE_W),
        .NUM_SLOTS   (NS),
        .MAX_FAIL    (3),
        .LOCK_CYCLES (20)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .code_in      (code_in),
        .confirm      (confirm),
        .slot_codes   (slot_codes),
        .slot_valid   (slot_valid),
        .busy         (busy),
        .match        (match),
        .fail         (fail),
        .match_slot   (match_slot),
        .match_master (match_master),
        .locked       (locked),
        .fail_count   (fail_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One full attempt: confirm, then 5 cycles to the result pulse, then one cycle after it.
    task automatic attempt(input string tag, input logic [CODE_W-1:0] code,
                           input logic exp_match, input logic [1:0] exp_slot,
                           input logic exp_master, input logic [1:0] exp_fc,
                           input logic exp_locked);
        code_in = code;
        confirm = 1'b1;
        step();
        confirm = 1'b0;
        chk({tag, ".busy_rise"}, busy, 1'b1);
        repeat (3) step();
        step();
        chk({tag, ".no_early_pulse"}, {match, fail, busy}, 3'b001);
        step();
        chk({tag, ".match"}, match, exp_match);
        chk({tag, ".fail"}, fail, !exp_match);
        if (exp_match) begin
            chk({tag, ".slot"}, match_slot, exp_slot);
            chk({tag, ".master"}, match_master, exp_master);
        end
        chk({tag, ".fail_count"}, fail_count, exp_fc);
        chk({tag, ".locked"}, locked, exp_locked);
        chk({tag, ".busy_fall"}, busy, 1'b0);
        step();
        chk({tag, ".pulse_1cyc"}, {match, fail}, 2'b00);
        $display("attempt %s code=%0h match=%0b slot=%0d fc=%0d locked=%0b",
                 tag, code, exp_match, exp_slot, exp_fc, exp_locked);
    endtask

    initial begin
        rst_n      = 1'b0;
        confirm    = 1'b0;
        code_in    = '0;
        slot_codes = {C3, C2, C1, C0};
        slot_valid = 4'b1111;
        repeat (3) step();
        chk("reset.outputs", {busy, match, fail, match_master, locked, match_slot, fail_count}, 9'd0);
        rst_n = 1'b1;
        step();

        // Basic match on a user slot
        attempt("slot2", C2, 1'b1, 2'd2, 1'b0, 2'd0, 1'b0);

        // Duplicate code in slots 1 and 3, with slot 1 invalid, reports slot 3
        slot_codes = {CX, C2, CX, C0};
        slot_valid = 4'b1101;
        attempt("dup_invalid", CX, 1'b1, 2'd3, 1'b0, 2'd0, 1'b0);
        // Making slot 0 equal as well gives the master index
        slot_codes = {CX, C2, CX, CX};
        slot_valid = 4'b1111;
        attempt("dup_master", CX, 1'b1, 2'd0, 1'b1, 2'd0, 1'b0);

        // Three failures lock the block for 20 cycles
        slot_codes = {C3, C2, C1, C0};
        attempt("lk_f1", CW, 1'b0, 2'd0, 1'b0, 2'd1, 1'b0);
        attempt("lk_f2", CW, 1'b0, 2'd0, 1'b0, 2'd2, 1'b0);
        attempt("lk_f3", CW, 1'b0, 2'd0, 1'b0, 2'd3, 1'b1);
        for (int i = 0; i < 19; i++) begin
            if (i == 5) confirm = 1'b0;
            chk("lock.held", locked, 1'b1);
            chk("lock.no_pulse", {match, fail}, 2'b00);
            if (i == 4) begin
                code_in = C2;
                confirm = 1'b1;
            end
            step();
        end
        chk("lock.released", locked, 1'b0);
        chk("lock.fc_cleared", fail_count, 2'd0);
        $display("lockout held 20 cycles then released");
        step();
        chk("lock.no_late_pulse", {match, fail, busy}, 3'b000);

        // A match in between resets the consecutive failure count
        attempt("mix_f1", CW, 1'b0, 2'd0, 1'b0, 2'd1, 1'b0);
        attempt("mix_f2", CW, 1'b0, 2'd0, 1'b0, 2'd2, 1'b0);
        attempt("mix_ok", C1, 1'b1, 2'd1, 1'b0, 2'd0, 1'b0);
        attempt("mix_f3", CW, 1'b0, 2'd0, 1'b0, 2'd1, 1'b0);
        attempt("mix_f4", CW, 1'b0, 2'd0, 1'b0, 2'd2, 1'b0);

        // Reset while scanning slot 2
        code_in = C1;
        confirm = 1'b1;
        step();
        confirm = 1'b0;
        step();
        step();
        chk("rst_mid.busy_before", busy, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("rst_mid.outputs", {busy, match, fail, match_master, locked, match_slot, fail_count}, 9'd0);
        step();
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            chk("rst_mid.no_pulse", {match, fail, busy}, 3'b000);
        end
        $display("reset mid-scan discarded the attempt");
        attempt("after_rst", C1, 1'b1, 2'd1, 1'b0, 2'd0, 1'b0);

`ifdef MASTER_OVERRIDE_EN
        attempt("ov_f1", CW, 1'b0, 2'd0, 1'b0, 2'd1, 1'b0);
        attempt("ov_f2", CW, 1'b0, 2'd0, 1'b0, 2'd2, 1'b0);
        attempt("ov_f3", CW, 1'b0, 2'd0, 1'b0, 2'd3, 1'b1);
        repeat (3) step();
        code_in = C2;
        confirm = 1'b1;
        step();
        confirm = 1'b0;
        chk("ov.user_ignored", {match, fail, locked}, 3'b001);
        chk("ov.user_fc", fail_count, 2'd3);
        step();
        code_in = C0;
        confirm = 1'b1;
        step();
        confirm = 1'b0;
        chk("ov.match", match, 1'b1);
        chk("ov.master", match_master, 1'b1);
        chk("ov.slot", match_slot, 2'd0);
        chk("ov.unlocked", locked, 1'b0);
        chk("ov.fc", fail_count, 2'd0);
        $display("master override ended lockout");
        step();
        chk("ov.pulse_1cyc", {match, fail, locked}, 3'b000);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
